// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 master arbiter.
package axi4_arb_pkg;

  typedef logic port_t;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_st_t;

  // Burst control fields. The ID and address widths come from module
  // parameters, so the full request struct is completed in the top.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ax_ctl_t;

  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] BURST_INCR    = 2'b01;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/axi4_arb_route_fifo.sv
// W-route FIFO: records {port, id} of each accepted AW so W beats follow grant order.
module axi4_arb_route_fifo
  import axi4_arb_pkg::*;
#(
  parameter int C_W     = 3,
  parameter int C_DEPTH = 4
)(
  input  logic           CLK,
  input  logic           RST,
  input  logic           i_push,
  input  logic [C_W-1:0] i_din,
  input  logic           i_pop,
  output logic [C_W-1:0] o_dout,
  output logic           o_full,
  output logic           o_empty
);
  localparam int PW = fifo_ptr_w(C_DEPTH);

  logic [PW:0]    r_wr, r_rd;
  logic [C_W-1:0] r_mem [C_DEPTH];
  logic           w_do_push, w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
  // A pop frees the head slot this cycle, so a push into a full FIFO is fine then.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd[PW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/axi4_master_arbiter.sv
// Two-requester AXI4 master arbiter: round-robin AR/AW, ID-routed R/B, FIFO-ordered W.
module axi4_master_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int C_ID_WIDTH    = 2,
  parameter int C_ADDR_WIDTH  = 32,
  parameter int C_DATA_WIDTH  = 512,
  parameter int C_WFIFO_DEPTH = 4
)(
  input  logic CLK, RST,
  input  logic [C_ID_WIDTH-1:0] S0_ARID, S1_ARID,
  input  logic [C_ADDR_WIDTH-1:0] S0_ARADDR, S1_ARADDR,
  input  logic [7:0] S0_ARLEN, S1_ARLEN,
  input  logic [2:0] S0_ARSIZE, S1_ARSIZE,
  input  logic [1:0] S0_ARBURST, S1_ARBURST,
  input  logic S0_ARVALID, S1_ARVALID,
  output logic S0_ARREADY, S1_ARREADY,
  output logic [C_ID_WIDTH-1:0] S0_RID, S1_RID,
  output logic [C_DATA_WIDTH-1:0] S0_RDATA, S1_RDATA,
  output logic [1:0] S0_RRESP, S1_RRESP,
  output logic S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID,
  input  logic S0_RREADY, S1_RREADY,
  input  logic [C_ID_WIDTH-1:0] S0_AWID, S1_AWID,
  input  logic [C_ADDR_WIDTH-1:0] S0_AWADDR, S1_AWADDR,
  input  logic [7:0] S0_AWLEN, S1_AWLEN,
  input  logic [2:0] S0_AWSIZE, S1_AWSIZE,
  input  logic [1:0] S0_AWBURST, S1_AWBURST,
  input  logic S0_AWVALID, S1_AWVALID,
  output logic S0_AWREADY, S1_AWREADY,
  input  logic [C_DATA_WIDTH-1:0] S0_WDATA, S1_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] S0_WSTRB, S1_WSTRB,
  input  logic S0_WLAST, S1_WLAST, S0_WVALID, S1_WVALID,
  output logic S0_WREADY, S1_WREADY,
  output logic [C_ID_WIDTH-1:0] S0_BID, S1_BID,
  output logic [1:0] S0_BRESP, S1_BRESP,
  output logic S0_BVALID, S1_BVALID,
  input  logic S0_BREADY, S1_BREADY,
  output logic [C_ID_WIDTH:0] M_ARID,
  output logic [C_ADDR_WIDTH-1:0] M_ARADDR,
  output logic [7:0] M_ARLEN,
  output logic [2:0] M_ARSIZE,
  output logic [1:0] M_ARBURST,
  output logic M_ARVALID,
  input  logic M_ARREADY,
  input  logic [C_ID_WIDTH:0] M_RID,
  input  logic [C_DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0] M_RRESP,
  input  logic M_RLAST, M_RVALID,
  output logic M_RREADY,
  output logic [C_ID_WIDTH:0] M_AWID,
  output logic [C_ADDR_WIDTH-1:0] M_AWADDR,
  output logic [7:0] M_AWLEN,
  output logic [2:0] M_AWSIZE,
  output logic [1:0] M_AWBURST,
  output logic M_AWVALID,
  input  logic M_AWREADY,
  output logic [C_ID_WIDTH:0] M_WID,
  output logic [C_DATA_WIDTH-1:0] M_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_WSTRB,
  output logic M_WLAST, M_WVALID,
  input  logic M_WREADY,
  input  logic [C_ID_WIDTH:0] M_BID,
  input  logic [1:0] M_BRESP,
  input  logic M_BVALID,
  output logic M_BREADY,
  output logic [1:0] M_ARLOCK, M_AWLOCK,
  output logic [3:0] M_ARCACHE, M_AWCACHE,
  output logic [2:0] M_ARPROT, M_AWPROT,
  output logic [3:0] M_ARREGION, M_AWREGION,
  output logic [3:0] M_ARQOS, M_AWQOS
);
  localparam int IW = C_ID_WIDTH;

  typedef struct packed {
    logic [IW-1:0]           id;
    logic [C_ADDR_WIDTH-1:0] addr;
    ax_ctl_t                 ctl;
  } ax_req_t;

  // Channel index 0 = AR, 1 = AW; port index 0 = core, 1 = DMA.
  ax_req_t    w_req [2][2];
  logic [1:0] w_vld [2];
  logic [1:0] w_mrdy, w_win, w_go, w_hs;
  arb_st_t    w_nxt [2];
  arb_st_t    r_st  [2];
  ax_req_t    r_req [2];
  logic [1:0] r_gnt, r_last;

  logic          w_full, w_empty, w_pop, w_hport;
  logic [IW:0]   w_head;
  logic [IW-1:0] w_hid;

  assign w_req[0][0] = {S0_ARID, S0_ARADDR, S0_ARLEN, S0_ARSIZE, S0_ARBURST};
  assign w_req[0][1] = {S1_ARID, S1_ARADDR, S1_ARLEN, S1_ARSIZE, S1_ARBURST};
  assign w_req[1][0] = {S0_AWID, S0_AWADDR, S0_AWLEN, S0_AWSIZE, S0_AWBURST};
  assign w_req[1][1] = {S1_AWID, S1_AWADDR, S1_AWLEN, S1_AWSIZE, S1_AWBURST};
  assign w_vld[0]    = {S1_ARVALID, S0_ARVALID};
  assign w_vld[1]    = {S1_AWVALID, S0_AWVALID};
  assign w_mrdy      = {M_AWREADY, M_ARREADY};

  // Next-state and round-robin pick for both address channels. AW only opens a
  // grant with room in the route FIFO; nothing else can fill it during the grant.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_nxt[c] = r_st[c];
      w_win[c] = (w_vld[c] == 2'b11) ? ~r_last[c] : w_vld[c][1];
      w_go[c]  = (|w_vld[c]) && (c == 0 || !w_full);
      w_hs[c]  = (r_st[c] == ST_GRANT) && w_mrdy[c];
      case (r_st[c])
        ST_IDLE:  if (w_go[c]) w_nxt[c] = ST_GRANT;
        ST_GRANT: if (w_hs[c]) w_nxt[c] = ST_IDLE;
        default:  w_nxt[c] = ST_IDLE;
      endcase
    end
  end

  // Grant registers: winner and payload latched on entry, held until handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < 2; c++) begin
        r_st[c]  <= ST_IDLE;
        r_req[c] <= '0;
      end
      r_gnt  <= '0;
      r_last <= 2'b11;
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_st[c] <= w_nxt[c];
        if (r_st[c] == ST_IDLE && w_go[c]) begin
          r_gnt[c] <= w_win[c];
          r_req[c] <= w_req[c][w_win[c]];
        end
        if (w_hs[c]) r_last[c] <= r_gnt[c];
      end
    end
  end

  assign M_ARVALID  = (r_st[0] == ST_GRANT);
  assign M_ARID     = {r_gnt[0], r_req[0].id};
  assign M_ARADDR   = r_req[0].addr;
  assign M_ARLEN    = r_req[0].ctl.len;
  assign M_ARSIZE   = r_req[0].ctl.size;
  assign M_ARBURST  = r_req[0].ctl.burst;
  assign S0_ARREADY = w_hs[0] && !r_gnt[0];
  assign S1_ARREADY = w_hs[0] &&  r_gnt[0];

  assign M_AWVALID  = (r_st[1] == ST_GRANT);
  assign M_AWID     = {r_gnt[1], r_req[1].id};
  assign M_AWADDR   = r_req[1].addr;
  assign M_AWLEN    = r_req[1].ctl.len;
  assign M_AWSIZE   = r_req[1].ctl.size;
  assign M_AWBURST  = r_req[1].ctl.burst;
  assign S0_AWREADY = w_hs[1] && !r_gnt[1];
  assign S1_AWREADY = w_hs[1] &&  r_gnt[1];

  assign {M_ARLOCK, M_AWLOCK}     = '0;
  assign {M_ARCACHE, M_AWCACHE}   = {CACHE_DEFAULT, CACHE_DEFAULT};
  assign {M_ARPROT, M_AWPROT}     = '0;
  assign {M_ARREGION, M_AWREGION} = '0;
  assign {M_ARQOS, M_AWQOS}       = '0;

  axi4_arb_route_fifo #(.C_W(IW + 1), .C_DEPTH(C_WFIFO_DEPTH)) u_wroute (
    .CLK(CLK), .RST(RST),
    .i_push(w_hs[1]), .i_din({r_gnt[1], r_req[1].id}),
    .i_pop(w_pop), .o_dout(w_head), .o_full(w_full), .o_empty(w_empty)
  );

  assign w_hport = w_head[IW];
  assign w_hid   = w_head[IW-1:0];
  assign w_pop   = M_WVALID && M_WREADY && M_WLAST;

  // W mux driven by the FIFO head; idle (all zero) while no AW is outstanding.
  always_comb begin
    M_WVALID = 1'b0;
    M_WDATA  = '0;
    M_WSTRB  = '0;
    M_WLAST  = 1'b0;
    M_WID    = '0;
    if (!w_empty) begin
      M_WID = {w_hport, w_hid};
      if (w_hport) begin
        M_WVALID = S1_WVALID; M_WDATA = S1_WDATA; M_WSTRB = S1_WSTRB; M_WLAST = S1_WLAST;
      end else begin
        M_WVALID = S0_WVALID; M_WDATA = S0_WDATA; M_WSTRB = S0_WSTRB; M_WLAST = S0_WLAST;
      end
    end
  end

  assign S0_WREADY = M_WREADY && !w_empty && !w_hport;
  assign S1_WREADY = M_WREADY && !w_empty &&  w_hport;

  // Response routing by ID MSB; handshakes are forced low while in reset.
  assign S0_RID    = M_RID[IW-1:0];
  assign S1_RID    = M_RID[IW-1:0];
  assign S0_RDATA  = M_RDATA;
  assign S1_RDATA  = M_RDATA;
  assign S0_RRESP  = M_RRESP;
  assign S1_RRESP  = M_RRESP;
  assign S0_RLAST  = M_RLAST;
  assign S1_RLAST  = M_RLAST;
  assign S0_RVALID = !RST && M_RVALID && !M_RID[IW];
  assign S1_RVALID = !RST && M_RVALID &&  M_RID[IW];
  assign M_RREADY  = !RST && (M_RID[IW] ? S1_RREADY : S0_RREADY);

  assign S0_BID    = M_BID[IW-1:0];
  assign S1_BID    = M_BID[IW-1:0];
  assign S0_BRESP  = M_BRESP;
  assign S1_BRESP  = M_BRESP;
  assign S0_BVALID = !RST && M_BVALID && !M_BID[IW];
  assign S1_BVALID = !RST && M_BVALID &&  M_BID[IW];
  assign M_BREADY  = !RST && (M_BID[IW] ? S1_BREADY : S0_BREADY);

endmodule

// File: doc/axi4_master_arbiter.md
Name: axi4_master_arbiter

Overview:
Shares the single AXI4 master port toward the memory BFM between two requesters: port 0 is the processor core, port 1 is the HDMI scan-out DMA. AR and AW are arbitrated independently (round-robin, burst-granular). The requester index is prepended to the ID as its MSB, so R/B responses route back by ID. W beats follow AW grant order through a small route FIFO.

Parameters:
C_ID_WIDTH, 2, requester-side ID width; master-side ID is C_ID_WIDTH+1 bits, MSB = requester index
C_ADDR_WIDTH, 32, address width
C_DATA_WIDTH, 512, data width; strobe width = C_DATA_WIDTH/8
C_WFIFO_DEPTH, 4, W-route FIFO entries (power of 2, >=2)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
Sn_AR{ID,ADDR,LEN,SIZE,BURST,VALID} in / Sn_ARREADY out  n=0,1  C_ID_WIDTH,C_ADDR_WIDTH,8,3,2,1 / 1  requester read address
Sn_R{ID,DATA,RESP,LAST,VALID} out / Sn_RREADY in  n=0,1  C_ID_WIDTH,C_DATA_WIDTH,2,1,1 / 1  requester read data
Sn_AW{ID,ADDR,LEN,SIZE,BURST,VALID} in / Sn_AWREADY out  n=0,1  as AR  requester write address
Sn_W{DATA,STRB,LAST,VALID} in / Sn_WREADY out  n=0,1  C_DATA_WIDTH,C_DATA_WIDTH/8,1,1 / 1  requester write data
Sn_B{ID,RESP,VALID} out / Sn_BREADY in  n=0,1  C_ID_WIDTH,2,1 / 1  requester write response
M_AR{ID,ADDR,LEN,SIZE,BURST,VALID} out / M_ARREADY in  C_ID_WIDTH+1,... / 1  master read address
M_R{ID,DATA,RESP,LAST,VALID} in / M_RREADY out  master read data
M_AW{ID,ADDR,LEN,SIZE,BURST,VALID} out / M_AWREADY in  master write address
M_W{ID,DATA,STRB,LAST,VALID} out / M_WREADY in  master write data; M_WID = ID of the burst in flight
M_B{ID,RESP,VALID} in / M_BREADY out  master write response
M_{AR,AW}{LOCK,CACHE,PROT,REGION,QOS} out  2,4,3,4,4  constant 0, except CACHE=4'b0011

Behaviour:
- Reset: all *VALID/*READY outputs 0, payload outputs 0, round-robin pointers select port 0 first, W FIFO empty.
- AR arbiter FSM per channel: IDLE -> GRANT when any Sn_ARVALID. Grant = the requester after last_grant in round-robin order; a single requester wins immediately. Grant is registered, so M_ARVALID rises 1 cycle after the request. In GRANT, M_AR* is held stable from the registered copy. On M_ARVALID&&M_ARREADY: pulse Sn_ARREADY to the winner in the same cycle, update last_grant, return to IDLE. No grant change while M_ARVALID is high.
- AW arbiter: same FSM. Handshake is allowed only when the W FIFO is not full. On AW handshake, push the winner index together with its ID.
- Back-to-back: a new grant may issue the cycle after handshake (at most one AR and one AW accepted per 2 cycles).
- Simultaneous Sn_ARVALID on both ports: each is served in alternation. Neither port may be starved beyond one burst address.
- R routing: M_RID MSB selects the port. Sn_RID = M_RID[C_ID_WIDTH-1:0]. Sn_RVALID is gated to the addressed port. M_RREADY = selected Sn_RREADY. The path is combinational (0-cycle latency).
- B routing: same as R, using M_BID.
- W routing: the FIFO head selects the port. M_W* = the selected Sn_W*, and M_WID = the head ID with its MSB. Sn_WREADY = M_WREADY && FIFO non-empty && selected. Pop on M_WVALID&&M_WREADY&&M_WLAST.
- W data may precede AW (common on the processor side). It is held off by WREADY=0 until its AW entry is at the FIFO head.
- FIFO full: AW arbiter stalls; pending AW stays unaccepted. FIFO empty: M_WVALID=0.
- Reset mid-burst: everything returns to the reset state immediately. Outstanding master transactions are dropped; reset is system-wide.
- Out-of-range master ID MSB cannot occur (1-bit MSB, 2 ports).

Decomposition:
- Package axi4_arb_pkg: port index typedef (1 bit), ar/aw request struct (id, addr, len, size, burst), constants for CACHE/BURST_INCR and the FIFO pointer width.
- Sub-module axi4_arb_route_fifo: synchronous FIFO of {port, id}, depth C_WFIFO_DEPTH, full/empty flags, push/pop legal in the same cycle (including when full with a pop).

Test Plan:
- Single AR from S0 (ID=1, ADDR=0x1000, LEN=3) -> M_ARID=3'b001 one cycle later. 4 R beats with M_RID=3'b001 appear only on S0, and S0_RLAST arrives on the 4th.
- S0 and S1 both hold ARVALID for 4 bursts each -> M_ARID MSB sequence 0,1,0,1,0,1,0,1, and neither port waits more than one burst.
- S1 AW (ID=2, LEN=7) with W data presented 3 cycles before AW -> S1_WREADY stays 0 until the AW handshake. 8 beats then pass with M_WID=3'b110, and B with M_BID=3'b110 routes to S1 only.
- Hold M_WREADY=0 and issue 5 AWs alternating ports with C_WFIFO_DEPTH=4 -> 4 accepted and the 5th AWREADY stays 0. Releasing WREADY drains the bursts in AW order, after which the 5th is accepted.
- Interleaved R responses (M_RID 3'b100, 3'b000 alternating) with S0_RREADY=0 -> S1 beats are delivered, and M_RREADY=0 on the S0-addressed beats.
- Assert RST mid W burst (beat 2 of 4) -> all VALID/READY outputs are 0 within the same cycle, the FIFO is empty after release, and the first post-reset AR goes to S0 when both request.
